lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_if.sv | 45 ++++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 width/sign
// codes, access sizes, FSM state encoding and decode helpers.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3: bits [1:0] select the access width, bit 2 selects zero-extension
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  // True for the opcode/funct3 pairs the unit executes on the bus
  function automatic logic op_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (opcode == OP_LOAD)
      ok = (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    else if (opcode == OP_STORE)
      ok = (funct3 inside {F3_B, F3_H, F3_W});
    return ok;
  endfunction

  // Byte offset after dropping the low address bits a wider access ignores
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] r;
    case (size)
      SZ_B:    r = off;
      SZ_H:    r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-stage request, data-bus and writeback signals of the LSU.
// Handshake: an op transfers on a rising edge where req_valid and req_ready
// are both high; upstream holds its fields stable while req_valid is high and
// req_ready is low. The bus side keeps mem_req and its fields stable until the
// edge on which mem_ack is high, which completes the access.
// modport slave is the LSU's view, modport master the surrounding pipeline.
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  lsu_state_t  fsm_state;

  modport slave (
    input  req_valid, opcode, funct3, addr, wdata, rd, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output done, wb_we, wb_rd, wb_data, err, fsm_state
  );

  modport master (
    output req_valid, opcode, funct3, addr, wdata, rd, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  done, wb_we, wb_rd, wb_data, err, fsm_state
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic of the LSU: store strobes and lane replication, load lane
// extraction with sign/zero extension, and the misalignment trap.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// trap instead of being silently aligned down).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wlanes,
  output logic        trap,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [1:0]  st_off_m;
  logic [1:0]  ld_off_m;
  logic [31:0] ld_sh;

  assign st_off_m = align_off(st_size, st_off);
  assign ld_off_m = align_off(ld_funct3[1:0], ld_off);
  assign ld_sh    = rdata >> {ld_off_m, 3'b000};

  // Store strobes select the addressed lanes; data is replicated across lanes
  always_comb begin
    wstrb  = 4'b1111;
    wlanes = st_wdata;
    case (st_size)
      SZ_B: begin
        wstrb  = 4'b0001 << st_off_m;
        wlanes = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        wstrb  = 4'b0011 << st_off_m;
        wlanes = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Half accesses need bit 0 clear, word accesses need both bits clear
  always_comb begin
    trap = 1'b0;
    case (st_size)
      SZ_H:    trap = st_off[0];
      SZ_W:    trap = |st_off;
      default: trap = 1'b0;
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  // Pick the addressed lane of the read word and extend it to 32 bits
  always_comb begin
    ld_data = ld_sh;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_BU:   ld_data = {24'h0, ld_sh[7:0]};
      F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_HU:   ld_data = {16'h0, ld_sh[15:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op at a time from execute, runs a single bus
// access with an ack timeout, and reports done/err plus load writeback.
// Op lifecycle: IDLE (accept) -> BUS (wait for ack) -> RESP -> IDLE, with
// done/err/wb_* registered out of RESP so they appear on the first IDLE cycle.
// Illegal ops skip BUS entirely.
// Optional feature macro: MISALIGN_TRAP_EN (see lsu_align).
module lsu
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        load_q;
  logic        fail_q;
  logic [31:0] ld_q;

  logic [3:0]  wstrb_w;
  logic [31:0] wlanes_w;
  logic        trap_w;
  logic [31:0] ld_data_w;
  logic        req_load;
  logic        req_store;
  logic        req_legal;

  // Store lanes come from the live request; load extraction from captured fields
  lsu_align u_align (
    .st_size   (bus.funct3[1:0]),
    .st_off    (bus.addr[1:0]),
    .st_wdata  (bus.wdata),
    .wstrb     (wstrb_w),
    .wlanes    (wlanes_w),
    .trap      (trap_w),
    .ld_funct3 (funct3_q),
    .ld_off    (off_q),
    .rdata     (bus.mem_rdata),
    .ld_data   (ld_data_w)
  );

  assign req_load  = (bus.opcode == OP_LOAD);
  assign req_store = (bus.opcode == OP_STORE);
  assign req_legal = op_legal(bus.opcode, bus.funct3) && !trap_w;
  assign bus.fsm_state = state;

  // Control FSM with registered bus, handshake and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      rd_q          <= 5'd0;
      load_q        <= 1'b0;
      fail_q        <= 1'b0;
      ld_q          <= 32'h0;
      bus.req_ready <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wstrb <= 4'h0;
      bus.mem_wdata <= 32'h0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.wb_we     <= 1'b0;
      bus.wb_rd     <= 5'd0;
      bus.wb_data   <= 32'h0;
    end else begin
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
      bus.wb_we   <= 1'b0;
      bus.wb_rd   <= 5'd0;
      bus.wb_data <= 32'h0;
      case (state)
        S_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            funct3_q      <= bus.funct3;
            off_q         <= bus.addr[1:0];
            rd_q          <= bus.rd;
            load_q        <= req_load;
            bus.req_ready <= 1'b0;
            if (req_legal) begin
              state         <= S_BUS;
              fail_q        <= 1'b0;
              cnt           <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= req_store;
              bus.mem_addr  <= {bus.addr[31:2], 2'b00};
              bus.mem_wstrb <= req_store ? wstrb_w : 4'h0;
              bus.mem_wdata <= req_store ? wlanes_w : 32'h0;
            end else begin
              state  <= S_RESP;
              fail_q <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (bus.mem_ack || cnt == CW'(ACK_TIMEOUT - 1)) begin
            state         <= S_RESP;
            fail_q        <= !bus.mem_ack;
            ld_q          <= ld_data_w;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wstrb <= 4'h0;
            bus.mem_wdata <= 32'h0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
          bus.done      <= 1'b1;
          bus.err       <= fail_q;
          if (load_q && !fail_q) begin
            bus.wb_we   <= (rd_q != 5'd0);
            bus.wb_rd   <= rd_q;
            bus.wb_data <= ld_q;
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
